rr_grant_ctrl_4: RTL and testbench
==================================

Name: rr_grant_ctrl_4

Overview:
- Round-robin arbiter/controller that shares one resource among 4 requesters.
- Selects a winner index and drives a registered one-hot grant through a 2-to-4 decode of that index.
- Holds the grant until the owner signals done, the owner drops its request, or a hold timeout fires.
- Sits in front of any shared unit (bus port, memory bank, decoder-driven mux) in the primary-circuits library.

Parameters:
- MAX_HOLD, 16, maximum grant duration in cycles; 0 disables the timeout; otherwise legal range is 2..2^CNT_W-1.
- CNT_W, 8, width of the hold counter.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high.
- en  input  1  allows new grants; an existing grant is unaffected when en=0.
- req  input  4  request vector; bit i is requester i.
- done  input  1  single-cycle release pulse from the current owner.
- gnt  output  4  one-hot grant, registered; 4'b0000 when no grant is active.
- gnt_idx  output  2  binary index of the current or last owner.
- busy  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (rst=1 at a clock edge, from any state, including mid-grant):
  - state=IDLE, gnt=0, gnt_idx=0, busy=0, timeout=0, ptr=0, hold count=0.
  - The grant is dropped on the next edge with no handshake.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - If en=1 and req!=0, pick the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the next edge: gnt=decode(winner), gnt_idx=winner, busy=1, count=0, state=BUSY.
  - Latency: req sampled at edge N, gnt visible after edge N+1 (one cycle).
  - done is ignored in IDLE.
- BUSY (owner o = gnt_idx): release at the next edge if any of these holds, evaluated in this priority order:
  - (a) done=1;
  - (b) req[o]=0;
  - (c) MAX_HOLD!=0 and count==MAX_HOLD-1. Only in this case, timeout=1 in the cycle after release.
- Otherwise count increments by 1; it never wraps because of the MAX_HOLD constraint.
- Release actions:
  - gnt=0, busy=0, state=IDLE, ptr=o+1 (mod 4, so 3 wraps to 0).
  - gnt_idx keeps o.
- Back-to-back grants: release is always followed by at least one IDLE cycle with gnt=0. The minimum period between grants is 2 cycles.
- Simultaneous events:
  - done together with the timeout condition: done wins, timeout stays 0.
  - Changes to requests from non-owners during BUSY are ignored until IDLE.
- timeout is high for exactly one cycle and is otherwise 0.
- gnt is always one-hot or zero and equals decode(gnt_idx) whenever busy=1.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=1'b0, ST_BUSY=1'b1;
  - requester count NREQ=4.
- One natural sub-module: grant_dec_2to4, a combinational 2-to-4 decoder (index -> one-hot), instantiated on the next-winner path.
- Rotating priority pick and FSM stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=4'b1111 -> gnt=0, busy=0, gnt_idx=0. Then release rst -> after 1 cycle gnt=4'b0001, gnt_idx=0.
- Round-robin order: req=4'b1111 held, done pulsed 2 cycles after each grant -> grants in sequence 0001, 0010, 0100, 1000, 0001, each separated by exactly one gnt=0 cycle.
- Skip and wrap: ptr=3 (last owner 2), req=4'b0011 -> gnt=4'b0001, not 0010; next release with req=4'b0011 -> gnt=4'b0010.
- Timeout: MAX_HOLD=4, req=4'b0100 held, no done -> gnt=4'b0100 for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle. Regrant 0100 the following cycle.
- Done vs timeout collision: MAX_HOLD=4, done pulsed on the 4th grant cycle -> release with timeout=0. Also check: owner drops req mid-grant -> release next edge, timeout=0.
- en and reset mid-grant: en=0 with req=4'b1000 -> no grant. Set en=1 -> gnt=4'b1000. Then deassert en while busy -> grant holds. Then rst=1 mid-grant -> next edge gnt=0, ptr=0, so req=4'b1001 after reset grants 0001.

Source files
------------

// File: rtl/rr_grant_ctrl_4_pkg.sv
// Shared types for the 4-way round-robin grant controller.
// Holds state encodings and requester sizing.
package rr_grant_ctrl_4_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef logic [NREQ-1:0]  req_t;
  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/rr_grant_ctrl_4_if.sv
// Request/grant bundle between requesters and the arbiter.
// master drives requests; slave is the arbiter.
interface rr_grant_ctrl_4_if;
  import rr_grant_ctrl_4_pkg::*;

  logic en;
  req_t req;
  logic done;
  req_t gnt;
  idx_t gnt_idx;
  logic busy;
  logic timeout;

  modport master (
    output en, req, done,
    input  gnt, gnt_idx, busy, timeout
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_idx, busy, timeout
  );

endinterface

// File: rtl/rr_grant_ctrl_4_dec.sv
// Combinational 2-to-4 index decoder.
// Produces the one-hot grant for the next winner.
module grant_dec_2to4
  import rr_grant_ctrl_4_pkg::*;
(
  input  idx_t idx_i,
  output req_t onehot_o
);

  always_comb begin
    onehot_o = '0;
    onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_ctrl_4.sv
// Round-robin arbiter for 4 requesters with done/drop/timeout release.
// Registered one-hot grant; rotating pointer advances past each owner.
module rr_grant_ctrl_4
  import rr_grant_ctrl_4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input logic clk,
  input logic rst,
  rr_grant_ctrl_4_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_e state_q, state_d;
  req_t   gnt_q, gnt_d, dec_gnt;
  idx_t   idx_q, idx_d;
  idx_t   ptr_q, ptr_d;
  idx_t   win_idx;
  logic   win_vld;
  logic   [CNT_W-1:0] cnt_q, cnt_d;
  logic   tmo_q, tmo_d;
  logic   rel_done, rel_drop, rel_hold, rel;

  // Scan high to low offset so the lowest offset from ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[ptr_q + idx_t'(k)]) begin
        win_vld = 1'b1;
        win_idx = ptr_q + idx_t'(k);
      end
    end
  end

  grant_dec_2to4 u_dec (
    .idx_i    (win_idx),
    .onehot_o (dec_gnt)
  );

  assign rel_done = bus.done;
  assign rel_drop = ~bus.req[idx_q];
  assign rel_hold = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
  assign rel      = rel_done | rel_drop | rel_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.en && win_vld) state_d = ST_BUSY;
      ST_BUSY: if (rel) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d = gnt_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    tmo_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.en && win_vld) begin
          gnt_d = dec_gnt;
          idx_d = win_idx;
          cnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (rel) begin
          gnt_d = '0;
          ptr_d = idx_q + idx_t'(1);
          // Timeout flags only when the hold limit alone caused release.
          tmo_d = ~rel_done & ~rel_drop;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.gnt     = gnt_q;
    bus.gnt_idx = idx_q;
    bus.busy    = (state_q == ST_BUSY);
    bus.timeout = tmo_q;
  end

endmodule

// File: tb/tb_rr_grant_ctrl_4.sv
// Scoreboard bench for rr_grant_ctrl_4 with a behavioural reference.
// Directed plan scenarios followed by randomized traffic.
module tb_rr_grant_ctrl_4;

  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst;

  rr_grant_ctrl_4_if bus();

  rr_grant_ctrl_4 #(
    .MAX_HOLD (MH),
    .CNT_W    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];

  logic       s_rst = 1'b1;
  logic       s_en  = 1'b1;
  logic [3:0] s_req = 4'b0000;
  int         s_dage = -1;
  bit         s_rnd = 1'b0;

  int m_owner = -1;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_age   = 0;
  bit m_tmo   = 1'b0;

  function automatic void chk(string nm, logic [7:0] act,
                              logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endfunction

  function automatic void model_step(bit r, bit e, logic [3:0] q,
                                     bit d);
    bit found;
    m_tmo = 1'b0;
    if (r) begin
      m_owner = -1;
      m_last  = 0;
      m_ptr   = 0;
      m_age   = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      if (e) begin
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (m_ptr + k) % 4;
          if (!found && q[c]) begin
            found   = 1'b1;
            m_owner = c;
            m_last  = c;
            m_age   = 0;
          end
        end
      end
    end else if (d || !q[m_owner] || (MH != 0 && m_age == MH - 1)) begin
      m_tmo   = !d && q[m_owner];
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end else begin
      m_age++;
    end
  endfunction

  function automatic logic [7:0] model_out();
    logic [3:0] g;
    g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    return {g, 2'(m_last), m_owner >= 0, m_tmo};
  endfunction

  // Driver: applies the current stimulus and predicts the next outputs.
  initial begin
    bit d;
    forever begin
      @(negedge clk);
      d = (m_owner >= 0 && m_age == s_dage) ||
          (s_rnd && $urandom_range(3) == 0);
      rst      = s_rst;
      bus.en   = s_en;
      bus.req  = s_req;
      bus.done = d;
      model_step(s_rst, s_en, s_req, d);
      exp_q.push_back(model_out());
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0)
        chk("cycle", {bus.gnt, bus.gnt_idx, bus.busy, bus.timeout},
            exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_g(string nm, logic [3:0] e);
    chk(nm, {4'b0000, bus.gnt}, {4'b0000, e});
  endtask

  logic [3:0] rr_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    s_rst = 1'b1; s_en = 1'b1; s_req = 4'b1111; s_dage = -1;
    cyc(2);
    chk("rst_state", {bus.gnt, bus.gnt_idx, bus.busy, bus.timeout},
        8'h00);
    s_rst = 1'b0;
    cyc(1);
    chk_g("first_gnt", 4'b0001);

    s_dage = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(2);
      chk_g("rr_gap", 4'b0000);
      cyc(1);
      chk_g("rr_order", rr_seq[i]);
    end

    s_dage = 0; s_req = 4'b0100;
    cyc(2);
    chk_g("own2", 4'b0100);
    s_req = 4'b0011; s_dage = -1;
    cyc(2);
    chk_g("wrap", 4'b0001);
    s_dage = 0;
    cyc(2);
    chk_g("skip", 4'b0010);

    s_req = 4'b0100; s_dage = -1;
    cyc(2);
    chk_g("tmo_gnt", 4'b0100);
    cyc(3);
    chk_g("tmo_hold", 4'b0100);
    cyc(1);
    chk("tmo_pulse", {bus.gnt, 3'b000, bus.timeout}, 8'b0000_0001);
    cyc(1);
    chk("tmo_regnt", {bus.gnt, 3'b000, bus.timeout}, 8'b0100_0000);

    s_dage = 3;
    cyc(4);
    chk("collide", {bus.gnt, bus.gnt_idx, bus.busy, bus.timeout},
        8'b0000_10_0_0);
    cyc(1);
    chk_g("collide_regnt", 4'b0100);
    s_dage = -1;
    cyc(1);
    chk_g("drop_hold", 4'b0100);
    s_req = 4'b0000;
    cyc(1);
    chk("drop_rel", {bus.gnt, 3'b000, bus.timeout}, 8'h00);

    s_en = 1'b0; s_req = 4'b1000;
    cyc(3);
    chk_g("en_off", 4'b0000);
    s_en = 1'b1;
    cyc(1);
    chk_g("en_on", 4'b1000);
    s_en = 1'b0;
    cyc(2);
    chk("en_hold", {bus.gnt, 3'b000, bus.busy}, 8'b1000_0001);
    s_rst = 1'b1;
    cyc(1);
    chk("mid_rst", {bus.gnt, bus.gnt_idx, bus.busy, bus.timeout}, 8'h00);
    s_rst = 1'b0; s_en = 1'b1; s_req = 4'b1001;
    cyc(1);
    chk_g("post_rst", 4'b0001);

    s_rnd = 1'b1;
    repeat (150) begin
      s_rst  = ($urandom_range(40) == 0);
      s_en   = ($urandom_range(5) != 0);
      s_req  = 4'($urandom);
      s_dage = int'($urandom_range(5)) - 1;
      cyc(int'($urandom_range(4, 1)));
    end
    s_rnd = 1'b0; s_rst = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
